// File: rtl/xdata_arb_pkg.sv
// xdata_arb_pkg: shared types and constants for the XDATA RAM arbiter.
//   slot_t   - per-cycle owner of the single RAM port, listed in priority order
//   STARVE_W - width of the DMA starvation counter
package xdata_arb_pkg;

  localparam int STARVE_W = 4;

  typedef enum logic [2:0] {
    SLOT_NONE,
    SLOT_FORCE_DMA,
    SLOT_WBUF_FORCED,
    SLOT_CPU_RD_PEND,
    SLOT_CPU_RD,
    SLOT_CPU_WR,
    SLOT_WBUF,
    SLOT_DMA
  } slot_t;

  function automatic logic slot_is_dma(slot_t s);
    return (s == SLOT_FORCE_DMA) || (s == SLOT_DMA);
  endfunction

endpackage

// File: rtl/xdata_arbiter_if.sv
// xdata_arbiter_if: bundle of CPU XDATA, DMA requester and RAM port signals.
//   cpu_*  - r8051 XDATA read/write port and read return (data + valid)
//   dma_*  - DMA/debug request, grant and read return
//   mem_*  - single-port synchronous-read RAM port
// Modports: slave = arbiter side, master = core/DMA/RAM environment side.
interface xdata_arbiter_if #(
  parameter int AW = 7
);
  logic          cpu_rd_en;
  logic [15:0]   cpu_rd_addr;
  logic          cpu_wr_en;
  logic [15:0]   cpu_wr_addr;
  logic [7:0]    cpu_wr_byte;
  logic [7:0]    cpu_rd_byte;
  logic          cpu_rd_vld;

  logic          dma_req;
  logic          dma_we;
  logic [AW-1:0] dma_addr;
  logic [7:0]    dma_wdata;
  logic          dma_gnt;
  logic          dma_rvld;
  logic [7:0]    dma_rdata;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic [7:0]    mem_rdata;

  modport slave (
    input  cpu_rd_en, cpu_rd_addr, cpu_wr_en, cpu_wr_addr, cpu_wr_byte,
    input  dma_req, dma_we, dma_addr, dma_wdata, mem_rdata,
    output cpu_rd_byte, cpu_rd_vld, dma_gnt, dma_rvld, dma_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output cpu_rd_en, cpu_rd_addr, cpu_wr_en, cpu_wr_addr, cpu_wr_byte,
    output dma_req, dma_we, dma_addr, dma_wdata, mem_rdata,
    input  cpu_rd_byte, cpu_rd_vld, dma_gnt, dma_rvld, dma_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/xdata_wbuf.sv
// xdata_wbuf: one-entry posted write buffer for CPU XDATA writes.
//   clk, rst            - clock, async active-low reset (drops the entry)
//   load                - capture ld_addr/ld_data; wins over drain so a
//                         drain-and-replace in one cycle keeps the new entry
//   drain               - entry written to RAM this cycle, clear valid
//   cmp_addr -> hit     - combinational match of a read address to the entry
//   vld, addr, data     - current entry
module xdata_wbuf #(
  parameter int AW = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          drain,
  input  logic [AW-1:0] ld_addr,
  input  logic [7:0]    ld_data,
  input  logic [AW-1:0] cmp_addr,
  output logic          vld,
  output logic [AW-1:0] addr,
  output logic [7:0]    data,
  output logic          hit
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld  <= 1'b0;
      addr <= '0;
      data <= '0;
    end else if (load) begin
      vld  <= 1'b1;
      addr <= ld_addr;
      data <= ld_data;
    end else if (drain) begin
      vld  <= 1'b0;
    end
  end

  assign hit = vld && (addr == cmp_addr);

endmodule

// File: rtl/xdata_arbiter.sv
// xdata_arbiter: shares the single-port XDATA RAM between the r8051 XDATA
// port and one DMA/debug requester.
//   clk, rst - clock, async active-low reset
//   bus      - xdata_arbiter_if.slave: CPU read/write port and read return,
//              DMA request/grant/read return, RAM port
// Parameters: AW (RAM address width), DMA_MAX_WAIT (refused DMA cycles
// before the DMA side forcibly takes the port, 1..15).
module xdata_arbiter
  import xdata_arb_pkg::*;
#(
  parameter int AW           = 7,
  parameter int DMA_MAX_WAIT = 4
) (
  input  logic               clk,
  input  logic               rst,
  xdata_arbiter_if.slave     bus
);

  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(DMA_MAX_WAIT);

  slot_t               slot;
  logic [AW-1:0]       cpu_rd_a;
  logic [AW-1:0]       cpu_wr_a;
  logic [AW-1:0]       rd_addr;
  logic [AW-1:0]       pend_addr;
  logic                pend_vld;
  logic                pend_nxt;
  logic                rd_defer;
  logic                wbuf_vld;
  logic [AW-1:0]       wbuf_addr;
  logic [7:0]          wbuf_data;
  logic                wbuf_hit;
  logic                wbuf_load;
  logic                wbuf_drain;
  logic [STARVE_W-1:0] starve_cnt;
  logic                dma_slot;
  logic                cpu_rd_served;
  logic                fwd_same;
  logic                fwd_hit;
  logic [7:0]          fwd_data;
  logic                cpu_ret_ram;
  logic                cpu_rd_vld_q;
  logic [7:0]          cpu_byte_q;
  logic                dma_rvld_q;
  logic                unused_addr_hi;

  // Upper address bits alias into the RAM.
  assign cpu_rd_a       = bus.cpu_rd_addr[AW-1:0];
  assign cpu_wr_a       = bus.cpu_wr_addr[AW-1:0];
  assign unused_addr_hi = ^{bus.cpu_rd_addr[15:AW], bus.cpu_wr_addr[15:AW]};

  // Slot choice is forced to NONE in reset so no access leaks out of it.
  always_comb begin
    slot = SLOT_NONE;
    if (!rst)                                         slot = SLOT_NONE;
    else if (bus.dma_req && starve_cnt == STARVE_MAX) slot = SLOT_FORCE_DMA;
    else if (wbuf_vld && bus.cpu_wr_en)               slot = SLOT_WBUF_FORCED;
    else if (pend_vld)                                slot = SLOT_CPU_RD_PEND;
    else if (bus.cpu_rd_en)                           slot = SLOT_CPU_RD;
    else if (bus.cpu_wr_en)                           slot = SLOT_CPU_WR;
    else if (wbuf_vld)                                slot = SLOT_WBUF;
    else if (bus.dma_req)                             slot = SLOT_DMA;
  end

  assign dma_slot      = slot_is_dma(slot);
  assign cpu_rd_served = (slot == SLOT_CPU_RD_PEND) || (slot == SLOT_CPU_RD);
  assign rd_addr       = (slot == SLOT_CPU_RD_PEND) ? pend_addr : cpu_rd_a;

  // A fresh read also sees the write arriving with it; a pending read only
  // sees the buffer, since any write in its serve cycle is younger.
  assign fwd_same = (slot == SLOT_CPU_RD) && bus.cpu_wr_en && (cpu_wr_a == cpu_rd_a);
  assign fwd_hit  = cpu_rd_served && (fwd_same || wbuf_hit);
  assign fwd_data = fwd_same ? bus.cpu_wr_byte : wbuf_data;

  // Under a forced DMA slot with the buffer full, the new write has nowhere
  // to go; the older entry is kept and the assertion below flags it.
  assign wbuf_load  = bus.cpu_wr_en && (slot != SLOT_CPU_WR) &&
                      !((slot == SLOT_FORCE_DMA) && wbuf_vld);
  assign wbuf_drain = (slot == SLOT_WBUF) || (slot == SLOT_WBUF_FORCED);

  xdata_wbuf #(.AW(AW)) u_wbuf (
    .clk      (clk),
    .rst      (rst),
    .load     (wbuf_load),
    .drain    (wbuf_drain),
    .ld_addr  (cpu_wr_a),
    .ld_data  (bus.cpu_wr_byte),
    .cmp_addr (rd_addr),
    .vld      (wbuf_vld),
    .addr     (wbuf_addr),
    .data     (wbuf_data),
    .hit      (wbuf_hit)
  );

  always_comb begin
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.dma_gnt   = 1'b0;
    case (slot)
      SLOT_FORCE_DMA, SLOT_DMA: begin
        bus.mem_en    = 1'b1;
        bus.mem_we    = bus.dma_we;
        bus.mem_addr  = bus.dma_addr;
        bus.mem_wdata = bus.dma_wdata;
        bus.dma_gnt   = 1'b1;
      end
      SLOT_WBUF_FORCED, SLOT_WBUF: begin
        bus.mem_en    = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_addr  = wbuf_addr;
        bus.mem_wdata = wbuf_data;
      end
      SLOT_CPU_RD_PEND, SLOT_CPU_RD: begin
        // Forwarded reads keep the slot for fixed latency but skip the RAM.
        bus.mem_en    = !fwd_hit;
        bus.mem_addr  = rd_addr;
      end
      SLOT_CPU_WR: begin
        bus.mem_en    = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_addr  = cpu_wr_a;
        bus.mem_wdata = bus.cpu_wr_byte;
      end
      default: ;
    endcase
  end

  // A read request while one is pending is ignored.
  assign rd_defer = bus.cpu_rd_en && !pend_vld && (slot != SLOT_CPU_RD);
  assign pend_nxt = rd_defer || (pend_vld && (slot != SLOT_CPU_RD_PEND));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_vld     <= 1'b0;
      pend_addr    <= '0;
      cpu_rd_vld_q <= 1'b1;
      starve_cnt   <= '0;
      cpu_ret_ram  <= 1'b0;
      cpu_byte_q   <= '0;
      dma_rvld_q   <= 1'b0;
    end else begin
      pend_vld     <= pend_nxt;
      cpu_rd_vld_q <= !pend_nxt;
      if (rd_defer) pend_addr <= cpu_rd_a;

      if (!bus.dma_req || dma_slot)   starve_cnt <= '0;
      else if (starve_cnt != STARVE_MAX) starve_cnt <= starve_cnt + 1'b1;

      cpu_ret_ram <= cpu_rd_served && !fwd_hit;
      dma_rvld_q  <= dma_slot && !bus.dma_we;

      // cpu_byte_q holds the last returned byte once the RAM output moves on.
      if (cpu_rd_served && fwd_hit) cpu_byte_q <= fwd_data;
      else if (cpu_ret_ram)         cpu_byte_q <= bus.mem_rdata;
    end
  end

  assign bus.cpu_rd_vld  = cpu_rd_vld_q;
  assign bus.cpu_rd_byte = cpu_ret_ram ? bus.mem_rdata : cpu_byte_q;
  assign bus.dma_rvld    = dma_rvld_q;
  assign bus.dma_rdata   = dma_rvld_q ? bus.mem_rdata : 8'h00;

  a_no_rd_while_pend: assert property (@(posedge clk) disable iff (!rst)
    !(bus.cpu_rd_en && pend_vld));

  a_no_write_drop: assert property (@(posedge clk) disable iff (!rst)
    !((slot == SLOT_FORCE_DMA) && wbuf_vld && bus.cpu_wr_en));

endmodule
